// File: rtl/module_display_scan_if.sv
// Bundle between the status/nibble source and the display scan controller.
// The master drives new frames in; the slave (scan controller) drives the
// shared 7-segment decoder input, the digit enables and the commit pulse.
interface module_display_scan_if;
    logic        load;
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  hex_out;
    logic [3:0]  anodo;
    logic        loaded;

    modport master (
        output load, data, blank,
        input  hex_out, anodo, loaded
    );

    modport slave (
        input  load, data, blank,
        output hex_out, anodo, loaded
    );
endinterface

// File: rtl/module_display_scan.sv
// Four-digit time-multiplexed scan controller for a common-anode display.
// Frames are loaded into a shadow copy and only committed to the displayed
// copy when the scan wraps from digit 3 back to digit 0, so a frame on the
// glass is never a mix of old and new digits.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_ON    | digit idx enabled (unless blanked) for REFRESH_DIV cycles
//   ST_GUARD | all digits dark for GUARD_CYCLES cycles, idx held
//
// Leaving ST_GUARD with idx=3 is the frame boundary (commit point).
module module_display_scan #(
    parameter int REFRESH_DIV  = 27000,
    parameter int GUARD_CYCLES = 270
) (
    input  logic                  clk,
    input  logic                  rst,
    module_display_scan_if.slave  bus
);
    localparam int MAXC = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] ON_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GD_LAST = CW'(GUARD_CYCLES - 1);

    typedef enum logic {ST_ON, ST_GUARD} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_idx;
    logic [1:0]     w_idx_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_commit;

    logic [15:0]    r_shadow_data;
    logic [3:0]     r_shadow_blank;
    logic           r_pending;
    logic [15:0]    r_disp_data;
    logic [3:0]     r_disp_blank;
    logic           r_loaded;
    logic [3:0]     w_anodo;

    // Scan state, digit index and window counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_GUARD;
            r_idx   <= 2'd3;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: count the current window, advance at its last cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_commit    = 1'b0;
        case (r_state)
            ST_ON: begin
                if (r_cnt == ON_LAST) begin
                    w_state_nxt = ST_GUARD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GUARD: begin
                if (r_cnt == GD_LAST) begin
                    w_state_nxt = ST_ON;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_commit    = (r_idx == 2'd3) && r_pending;
                end
            end
            default: begin
                w_state_nxt = ST_GUARD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Shadow capture, frame commit and the one-cycle commit pulse.
    // A load on the commit edge lands in the shadow while the old shadow
    // commits, so pending stays set for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_data  <= 16'h0000;
            r_shadow_blank <= 4'b1111;
            r_pending      <= 1'b0;
            r_disp_data    <= 16'h0000;
            r_disp_blank   <= 4'b1111;
            r_loaded       <= 1'b0;
        end else begin
            r_loaded <= w_commit;
            if (w_commit) begin
                r_disp_data  <= r_shadow_data;
                r_disp_blank <= r_shadow_blank;
            end
            if (bus.load) begin
                r_shadow_data  <= bus.data;
                r_shadow_blank <= bus.blank;
                r_pending      <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Digit enables decoded from registered state only, so no glitches.
    always_comb begin
        w_anodo = 4'b1111;
        if (r_state == ST_ON && !r_disp_blank[r_idx]) begin
            w_anodo = ~(4'b0001 << r_idx);
        end
    end

    assign bus.hex_out = r_disp_data[{r_idx, 2'b00} +: 4];
    assign bus.anodo   = w_anodo;
    assign bus.loaded  = r_loaded;
endmodule

// File: tb/tb_module_display_scan.sv
// Scoreboard bench for module_display_scan with REFRESH_DIV=4, GUARD_CYCLES=2.
// Stimulus pushes hand-computed commits (cycle of loaded pulse, frame); the
// monitor pops one on each loaded pulse and checks every cycle's digit output.
module tb_module_display_scan;
    localparam int RD = 4;
    localparam int GC = 2;
    localparam int FRAME = 4 * (RD + GC);

    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic [3:0]  b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];

    logic [15:0] cur_d;
    logic [3:0]  cur_b;

    module_display_scan_if bus();

    module_display_scan #(.REFRESH_DIV(RD), .GUARD_CYCLES(GC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle 1 is the first cycle after reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 1;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input int n, input logic [15:0] d, input logic [3:0] b);
        go_to(n);
        bus.load  = 1'b1;
        bus.data  = d;
        bus.blank = b;
        @(posedge clk);
        #1;
        bus.load  = 1'b0;
    endtask

    task automatic push(input int c, input logic [15:0] d, input logic [3:0] b);
        exp_t e;
        e.cyc = c;
        e.d   = d;
        e.b   = b;
        q.push_back(e);
    endtask

    // Monitor: consume expected commits on loaded, check digit outputs.
    always @(negedge clk) begin
        int p;
        int dg;
        logic [3:0] ea;
        logic [3:0] eh;
        exp_t e;
        if (rst) begin
            cur_d = 16'h0000;
            cur_b = 4'b1111;
        end else begin
            if (bus.loaded) begin
                if (q.size() == 0) begin
                    check("loaded_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("loaded_cycle", cyc, e.cyc);
                    cur_d = e.d;
                    cur_b = e.b;
                end
            end else if (q.size() > 0 && q[0].cyc == cyc) begin
                check("loaded_missing", 0, 1);
            end
            if (cyc < 3) begin
                ea = 4'b1111;
                eh = cur_d[15:12];
            end else begin
                p  = (cyc - 3) % FRAME;
                dg = p / (RD + GC);
                eh = cur_d[4*dg +: 4];
                if ((p % (RD + GC)) < RD && !cur_b[dg]) ea = ~(4'b0001 << dg);
                else                                    ea = 4'b1111;
            end
            check("anodo", int'(bus.anodo), int'(ea));
            check("hex_out", int'(bus.hex_out), int'(eh));
            check("anodo_one_low", ($countones(~bus.anodo) <= 1) ? 1 : 0, 1);
        end
    end

    initial begin
        bus.load  = 1'b0;
        bus.data  = 16'h0000;
        bus.blank = 4'b0000;

        // Reset, then 50 idle cycles: display stays dark, no commit.
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_anodo", int'(bus.anodo), 4'hF);
        check("rst_hold_hex", int'(bus.hex_out), 0);
        check("rst_hold_loaded", int'(bus.loaded), 0);
        rst = 1'b0;
        go_to(51);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic frame, committed at the first boundary.
        push(3, 16'h3E70, 4'b0000);
        do_load(1, 16'h3E70, 4'b0000);

        // Last wins within one frame.
        do_load(52, 16'h1111, 4'b0000);
        do_load(60, 16'h2222, 4'b0000);
        push(75, 16'h2222, 4'b0000);

        // Blanking of digits 0 and 2.
        do_load(80, 16'h4321, 4'b0101);
        push(99, 16'h4321, 4'b0101);

        // A before the boundary, B exactly on the commit edge (end of 122).
        do_load(110, 16'hABCD, 4'b0000);
        push(123, 16'hABCD, 4'b0000);
        do_load(122, 16'h5A5A, 4'b1000);
        push(147, 16'h5A5A, 4'b1000);

        // Pending load, then reset inside the digit 2 ON window.
        do_load(180, 16'h9876, 4'b0000);
        go_to(184);
        check("pre_rst_anodo", int'(bus.anodo), 4'b1011);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_anodo", int'(bus.anodo), 4'hF);
        check("rst_async_loaded", int'(bus.loaded), 0);
        check("rst_async_hex", int'(bus.hex_out), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        go_to(70);

        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/module_display_scan.md
# module_display_scan

Time-multiplexed scan controller for the shared 4→7 segment decoder path that drives the board's four-digit common-anode display. It holds a 4-nibble display frame and steps the shared decoder input through the digits, with one digit enabled at a time and a guard interval between digits. New frames arrive through a load strobe. They are committed only at a frame boundary, so a frame never shows a mix of old and new digits. The block sits between the Hamming/error status logic, which supplies the nibbles (error code, syndrome, data), and the existing 7-segment decoder instance.

## Interface
- REFRESH_DIV, default 27000: clock cycles each digit stays enabled (ON window); must be ≥1.
- GUARD_CYCLES, default 270: clock cycles with all digits off between ON windows; must be ≥1.
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high; all state is cleared immediately on assertion.
- load  input  1  single-cycle strobe that captures data/blank into the shadow registers.
- data  input  16  nibble i = data[4i+3:4i] is the value for digit i (digit 0 = rightmost).
- blank  input  4  per-digit blank mask; 1 = digit stays dark; captured with load.
- hex_out  output  4  nibble for the currently selected digit; feeds the shared 7-segment decoder.
- anodo  output  4  active-low digit enables; at most one bit is low at any time.
- loaded  output  1  one-cycle pulse asserted on the cycle after a frame commit.

## Operation
- Registers:
  - shadow_data[15:0] and shadow_blank[3:0]
  - pending flag
  - disp_data[15:0] and disp_blank[3:0]
  - digit index idx[1:0]
  - state in {ON, GUARD}
  - down/up counter sized to $clog2(max(REFRESH_DIV, GUARD_CYCLES)+1)
- On load, shadow_data/shadow_blank take data/blank and pending is set. A second load before commit overwrites the shadow (last wins), and only one commit results.
- FSM:
  - ON counts REFRESH_DIV cycles, then goes to GUARD with the same idx.
  - GUARD counts GUARD_CYCLES cycles, then goes to ON with idx+1, wrapping 3→0.
- Commit happens on the edge that leaves GUARD with idx=3, i.e. on entry to ON with idx=0. If pending=1 on that edge:
  - disp_* take shadow_*.
  - pending is cleared.
  - loaded is asserted for exactly the next cycle.
- If load is asserted on the commit edge itself:
  - The previous shadow contents are committed.
  - The new values go into the shadow and pending stays 1.
  - The new values commit at the next frame boundary.
- hex_out = disp_data nibble[idx]. It is combinational from registers, so there is no extra latency, and it is driven in both ON and GUARD.
- anodo:
  - In ON: ~(4'b0001 << idx), unless disp_blank[idx]=1, in which case 4'b1111.
  - In GUARD: always 4'b1111.
- Frame period is 4·(REFRESH_DIV+GUARD_CYCLES) cycles.

## Timing
- Values while rst is high and in the cycle after release:
  - state = GUARD, idx = 3, counter = 0, pending = 0
  - shadow/disp data = 0, shadow/disp blank = 4'b1111
  - Outputs: anodo = 4'b1111, hex_out = 4'h0, loaded = 0
- After release, the first ON (digit 0) begins GUARD_CYCLES cycles later. That first boundary commits a load made during those cycles.
- A load in cycle t is visible on the display no earlier than the next commit edge and no later than one frame plus one cycle after t.
- anodo and hex_out change only on clock edges, together with state/idx, so there is no glitch between digits.
- rst asserted mid-frame forces the reset values asynchronously. A pending load is discarded and any loaded pulse in progress is cut off.
- Simultaneous load and FSM transition are independent: the shadow updates and the FSM advances in the same cycle.

## Test plan
All scenarios use REFRESH_DIV=4 and GUARD_CYCLES=2, giving a 24-cycle frame.
- Reset: hold rst for 3 cycles, then release with no load → anodo=1111, hex_out=0, and loaded=0 for 50 cycles.
- Basic frame:
  - Stimulus: load data=16'h3E70, blank=0 in the first cycle after release.
  - loaded=1 in cycle 3.
  - Then per digit: digit0 anodo=1110 with hex_out=0 for 4 cycles, anodo=1111 for 2 cycles; digit1 anodo=1101 with hex_out=7; digit2 anodo=1011 with hex_out=E; digit3 anodo=0111 with hex_out=3.
  - The sequence repeats every 24 cycles.
- Last-wins:
  - Stimulus: load 16'h1111 and then 16'h2222 within the same frame.
  - The next frame shows only 2 on every digit, and exactly one loaded pulse occurs.
- Blanking: load data=16'h4321, blank=4'b0101 → anodo stays 1111 during the ON windows of digits 0 and 2. Digits 1 and 3 light with hex_out=2 and 4 respectively.
- Load on the commit edge:
  - Stimulus: load A, then load B exactly on the commit edge.
  - Frame N shows A and frame N+1 shows B.
  - loaded pulses occur 24 cycles apart.
- Mid-frame reset:
  - Stimulus: assert rst during the digit2 ON window, with a pending load outstanding.
  - anodo goes to 1111 immediately and loaded=0.
  - After release, no commit occurs without a fresh load.
